// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the fetch stage / memory port arbiter.
//   - iss_e      : kind of memory access issued in the previous cycle
//   - *_DEF      : default widths and reset PC used by ifetch_mem_arb
//   - iss_is_data: true for the two data-access kinds
package mem_arb_pkg;

    localparam int          ADDR_W_DEF   = 5;
    localparam int          DATA_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ISS_NONE  = 2'd0,
        ISS_FETCH = 2'd1,
        ISS_DRD   = 2'd2,
        ISS_DWR   = 2'd3
    } iss_e;

    function automatic logic iss_is_data(input iss_e kind);
        return (kind == ISS_DRD) || (kind == ISS_DWR);
    endfunction

endpackage

// File: rtl/ifetch_skid.sv
// ifetch_skid: two-entry instruction buffer (output register + one skid entry)
// carrying {instr, pc} toward ID.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush_i             drop both entries (redirect)
//   load_i              new {load_instr_i, load_pc_i} arrives this cycle
//   consume_i           downstream accepts the output entry this cycle
//   out_valid_o/instr/pc registered output entry
//   skid_full_o         skid entry occupied
module ifetch_skid #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_instr_i,
    input  logic [31:0]       load_pc_i,
    input  logic              consume_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_instr_o,
    output logic [31:0]       out_pc_o,
    output logic              skid_full_o
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_instr_q, out_instr_d;
    logic [31:0]       out_pc_q,    out_pc_d;
    logic              sk_valid_q,  sk_valid_d;
    logic [DATA_W-1:0] sk_instr_q,  sk_instr_d;
    logic [31:0]       sk_pc_q,     sk_pc_d;
    logic              take;

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        sk_valid_d  = sk_valid_q;
        sk_instr_d  = sk_instr_q;
        sk_pc_d     = sk_pc_q;
        take        = consume_i && out_valid_q;

        if (flush_i) begin
            out_valid_d = 1'b0;
            sk_valid_d  = 1'b0;
        end else begin
            // Consume first: a waiting skid entry slides into the output.
            if (take) begin
                if (sk_valid_q) begin
                    out_instr_d = sk_instr_q;
                    out_pc_d    = sk_pc_q;
                    sk_valid_d  = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            // New data goes to the output only if the output frees up and
            // nothing older is queued ahead of it.
            if (load_i) begin
                if ((!out_valid_q || take) && !sk_valid_q) begin
                    out_valid_d = 1'b1;
                    out_instr_d = load_instr_i;
                    out_pc_d    = load_pc_i;
                end else begin
                    sk_valid_d  = 1'b1;
                    sk_instr_d  = load_instr_i;
                    sk_pc_d     = load_pc_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            sk_valid_q  <= 1'b0;
            sk_instr_q  <= '0;
            sk_pc_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            sk_valid_q  <= sk_valid_d;
            sk_instr_q  <= sk_instr_d;
            sk_pc_q     <= sk_pc_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_instr_o = out_instr_q;
    assign out_pc_o    = out_pc_q;
    assign skid_full_o = sk_valid_q;

endmodule

// File: rtl/ifetch_mem_arb.sv
// ifetch_mem_arb: fetch stage plus single-port arbiter for the unified
// instruction/data memory (1-cycle synchronous read).
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   mem_w_en/mem_addr/mem_d_in/mem_d_out  memory port
//   if_instr/if_pc/if_valid, id_ready  fetched instruction stream to ID
//   redirect_valid/redirect_pc         branch/jump redirect
//   dm_req/dm_we/dm_addr/dm_wdata      MEM-stage data request (held to done)
//   dm_rdata/dm_done                   data response
// Optional macro IFETCH_PERF_EN adds perf_fetch_cnt and perf_steal_cnt.
module ifetch_mem_arb
    import mem_arb_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          DATA_W   = DATA_W_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d_in,
    input  logic [DATA_W-1:0] mem_d_out,
    output logic [DATA_W-1:0] if_instr,
    output logic [31:0]       if_pc,
    output logic              if_valid,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
`ifdef IFETCH_PERF_EN
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_steal_cnt,
`endif
    output logic              dm_done
);

    iss_e              iss_q, iss_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       fpc_q, fpc_d;       // pc of the fetch now in flight
    logic [DATA_W-1:0] rdata_q;
    logic              skid_full;
    logic              fetch_elig;
    logic              data_go;
    logic              fetch_resp;
    logic              unused_ok;

    assign unused_ok = ^{dm_addr[31:ADDR_W+2], dm_addr[1:0]};

    always_comb begin
        // A fetch whose response would land behind a stalled output is held
        // back, so at most one fetch ever needs the skid entry.
        fetch_elig = !skid_full
                   && !((iss_q == ISS_FETCH) && if_valid && !id_ready)
                   && !redirect_valid;
        // Data wins, but a held request is not reissued in its done cycle.
        // Gating with rst_n keeps the port quiet while reset is asserted.
        data_go    = rst_n && dm_req && !iss_is_data(iss_q);
        fetch_resp = (iss_q == ISS_FETCH) && !redirect_valid;

        mem_w_en = 1'b0;
        mem_addr = pc_q[ADDR_W+1:2];
        mem_d_in = '0;
        iss_d    = ISS_NONE;
        pc_d     = pc_q;
        fpc_d    = fpc_q;

        if (data_go) begin
            mem_addr = dm_addr[ADDR_W+1:2];
            mem_w_en = dm_we;
            mem_d_in = dm_wdata;
            iss_d    = dm_we ? ISS_DWR : ISS_DRD;
        end else if (fetch_elig) begin
            iss_d = ISS_FETCH;
            pc_d  = pc_q + 32'd4;
            fpc_d = pc_q;
        end

        // Fetch is never eligible during a redirect, so this cannot clash
        // with a pc increment.
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end

        dm_done  = iss_is_data(iss_q);
        dm_rdata = (iss_q == ISS_DRD) ? mem_d_out : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_q   <= ISS_NONE;
            pc_q    <= RESET_PC;
            fpc_q   <= '0;
            rdata_q <= '0;
        end else begin
            iss_q   <= iss_d;
            pc_q    <= pc_d;
            fpc_q   <= fpc_d;
            rdata_q <= dm_rdata;
        end
    end

    ifetch_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (redirect_valid),
        .load_i       (fetch_resp),
        .load_instr_i (mem_d_out),
        .load_pc_i    (fpc_q),
        .consume_i    (id_ready),
        .out_valid_o  (if_valid),
        .out_instr_o  (if_instr),
        .out_pc_o     (if_pc),
        .skid_full_o  (skid_full)
    );

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_steal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_steal_q <= '0;
        end else begin
            if (fetch_resp) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (data_go && fetch_elig) begin
                perf_steal_q <= perf_steal_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_steal_cnt = perf_steal_q;
`endif

endmodule
